// File: rtl/biquad8_pkg.sv
// biquad8_pkg -- shared definitions for the biquad8 coefficient loader.
//   COEFF_W : coefficient width carried to the FIR/IIR/incremental stages
//   SADR_W  : shadow-file index width (up to 32 entries)
//   state_t : loader sequencing states, in issue order
package biquad8_pkg;

  localparam int COEFF_W = 18;
  localparam int SADR_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIR0,
    ST_FIR1,
    ST_IIR,
    ST_INCR,
    ST_UPD
  } state_t;

  // States that issue one coefficient write per two cycles.
  function automatic logic is_wr_state(state_t s);
    return (s == ST_FIR0) || (s == ST_FIR1) || (s == ST_IIR) || (s == ST_INCR);
  endfunction

endpackage

// File: rtl/biquad8_coeff_shadow.sv
// biquad8_coeff_shadow -- host-visible shadow copy of all coefficients.
//   clk, rst_n        : clock, async active-low clear of every entry
//   i_wr_en/adr/dat   : single write port (caller guarantees adr < DEPTH)
//   i_rd_en/adr       : read request; o_rd_dat updates one cycle later and
//                       holds its value while i_rd_en is low
// A write and read of the same entry on one edge returns the new data, so a
// host write landing together with the load is what gets issued.
module biquad8_coeff_shadow
  import biquad8_pkg::*;
#(
  parameter int DEPTH = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_wr_en,
  input  logic [SADR_W-1:0]  i_wr_adr,
  input  logic [COEFF_W-1:0] i_wr_dat,
  input  logic               i_rd_en,
  input  logic [SADR_W-1:0]  i_rd_adr,
  output logic [COEFF_W-1:0] o_rd_dat
);

  logic [COEFF_W-1:0] r_mem [DEPTH];
  logic [COEFF_W-1:0] r_rd_dat;
  logic [COEFF_W-1:0] w_rd_mux;
  logic [COEFF_W-1:0] w_rd_src;

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i_rd_adr == SADR_W'(i)) w_rd_mux = r_mem[i];
  end

  assign w_rd_src = (i_wr_en && (i_wr_adr == i_rd_adr)) ? i_wr_dat : w_rd_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd_dat <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_wr_en && (i_wr_adr == SADR_W'(i))) r_mem[i] <= i_wr_dat;
      if (i_rd_en) r_rd_dat <= w_rd_src;
    end
  end

  assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/biquad8_coeff_loader.sv
// biquad8_coeff_loader -- loads the biquad8 FIR, IIR and incremental stage
// coefficient chains from a host-written shadow file.
//   clk, rst_n           : clock, async active-low reset
//   wr_i, adr_i, dat_i   : host shadow write (ignored + err_o when busy/out of range)
//   load_i               : start a load sequence (accepted only when idle)
//   busy_o, done_o       : sequence in progress / one-cycle completion pulse
//   err_o                : sticky bad-write flag, cleared by an accepted load
//   coeff_adr_o/dat_o    : coefficient bus to the stages (held between strobes)
//   fir_wr_o, iir_wr_o, incr_wr_o : per-stage shift strobes
//   coeff_update_o       : stages transfer shifted coefficients to active set
// Shadow layout is [FIR0 | FIR1 | IIR | INCR] from index 0. Each group is
// issued highest index first because the first value shifted in ends up in
// the deepest tap. Write k strobes two cycles apart starting one cycle after
// the load is accepted; the update pulse follows two idle cycles later.
module biquad8_coeff_loader
  import biquad8_pkg::*;
#(
  parameter int NFIR0 = 3,
  parameter int NFIR1 = 4,
  parameter int NIIR  = 7,
  parameter int NINCR = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_i,
  input  logic [SADR_W-1:0]  adr_i,
  input  logic [COEFF_W-1:0] dat_i,
  input  logic               load_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         coeff_adr_o,
  output logic [COEFF_W-1:0] coeff_dat_o,
  output logic               fir_wr_o,
  output logic               iir_wr_o,
  output logic               incr_wr_o,
  output logic               coeff_update_o
);

  // Group base indices into the shadow file; W must not exceed 32.
  localparam int B1 = NFIR0;
  localparam int B2 = B1 + NFIR1;
  localparam int B3 = B2 + NIIR;
  localparam int W  = B3 + NINCR;
  localparam logic [SADR_W:0] W_LIM = (SADR_W+1)'(W);

  // First non-empty group after s; later checks override earlier ones so the
  // earliest qualifying group wins.
  function automatic state_t grp_after(state_t s);
    state_t r;
    r = ST_UPD;
    if (NINCR > 0 && (s == ST_IDLE || s == ST_FIR0 || s == ST_FIR1 || s == ST_IIR)) r = ST_INCR;
    if (NIIR  > 0 && (s == ST_IDLE || s == ST_FIR0 || s == ST_FIR1)) r = ST_IIR;
    if (NFIR1 > 0 && (s == ST_IDLE || s == ST_FIR0)) r = ST_FIR1;
    if (NFIR0 > 0 && (s == ST_IDLE)) r = ST_FIR0;
    return r;
  endfunction

  function automatic logic [SADR_W-1:0] grp_hi(state_t s);
    case (s)
      ST_FIR0: grp_hi = SADR_W'(B1 - 1);
      ST_FIR1: grp_hi = SADR_W'(B2 - 1);
      ST_IIR:  grp_hi = SADR_W'(B3 - 1);
      ST_INCR: grp_hi = SADR_W'(W - 1);
      default: grp_hi = '0;
    endcase
  endfunction

  function automatic logic [SADR_W-1:0] grp_lo(state_t s);
    case (s)
      ST_FIR1: grp_lo = SADR_W'(B1);
      ST_IIR:  grp_lo = SADR_W'(B2);
      ST_INCR: grp_lo = SADR_W'(B3);
      default: grp_lo = '0;
    endcase
  endfunction

  state_t              r_state, w_nxt_state, w_grp_nxt;
  logic                r_ph, w_nxt_ph;     // 0: strobe cycle, 1: gap cycle
  logic [SADR_W-1:0]   r_idx, w_nxt_idx;   // shadow index of current write
  logic                w_rd_en;
  logic [1:0]          r_cadr;
  logic                r_err;
  logic                w_busy;
  logic                w_adr_ok;
  logic                w_sh_we;
  logic                w_bad_wr;
  logic                w_accept;
  logic [COEFF_W-1:0]  w_rd_dat;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_adr_ok  = ({1'b0, adr_i} < W_LIM);
  assign w_sh_we   = wr_i & ~w_busy & w_adr_ok;
  assign w_bad_wr  = wr_i & (w_busy | ~w_adr_ok);
  assign w_accept  = load_i & ~w_busy;
  assign w_grp_nxt = grp_after(r_state);

  biquad8_coeff_shadow #(
    .DEPTH (W)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_sh_we),
    .i_wr_adr (adr_i),
    .i_wr_dat (dat_i),
    .i_rd_en  (w_rd_en),
    .i_rd_adr (w_nxt_idx),
    .o_rd_dat (w_rd_dat)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ph    <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_ph    <= w_nxt_ph;
      r_idx   <= w_nxt_idx;
    end
  end

  // Next state. The shadow read for the next write is launched in the gap
  // cycle (or the accept cycle) so its data lands with the strobe.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ph    = r_ph;
    w_nxt_idx   = r_idx;
    w_rd_en     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nxt_state = w_grp_nxt;
          w_nxt_ph    = 1'b0;
          if (is_wr_state(w_grp_nxt)) begin
            w_nxt_idx = grp_hi(w_grp_nxt);
            w_rd_en   = 1'b1;
          end
        end
      end
      ST_FIR0, ST_FIR1, ST_IIR, ST_INCR: begin
        if (!r_ph) begin
          w_nxt_ph = 1'b1;
        end else begin
          w_nxt_ph = 1'b0;
          if (r_idx != grp_lo(r_state)) begin
            w_nxt_idx = r_idx - 1'b1;
            w_rd_en   = 1'b1;
          end else begin
            w_nxt_state = w_grp_nxt;
            if (is_wr_state(w_grp_nxt)) begin
              w_nxt_idx = grp_hi(w_grp_nxt);
              w_rd_en   = 1'b1;
            end
          end
        end
      end
      ST_UPD: begin
        if (!r_ph) begin
          w_nxt_ph = 1'b1;
        end else begin
          w_nxt_state = ST_IDLE;
          w_nxt_ph    = 1'b0;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_ph    = 1'b0;
      end
    endcase
  end

  // Sticky error and held coefficient address. A bad write in the same cycle
  // as an accepted load still leaves the error set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_cadr <= 2'd0;
    end else begin
      r_err <= w_bad_wr | (r_err & ~w_accept);
      if (is_wr_state(w_nxt_state))
        r_cadr <= (w_nxt_state == ST_FIR1) ? 2'd1 : 2'd0;
    end
  end

  // Outputs
  always_comb begin
    busy_o         = w_busy;
    err_o          = r_err;
    coeff_adr_o    = r_cadr;
    coeff_dat_o    = w_rd_dat;
    fir_wr_o       = ((r_state == ST_FIR0) || (r_state == ST_FIR1)) && !r_ph;
    iir_wr_o       = (r_state == ST_IIR)  && !r_ph;
    incr_wr_o      = (r_state == ST_INCR) && !r_ph;
    coeff_update_o = (r_state == ST_UPD)  && r_ph;
    done_o         = (r_state == ST_UPD)  && r_ph;
  end

endmodule
